bcd_serial_adder: RTL and testbench



---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_digit_add.sv | 34 +++
 rtl/bcd_serial_adder.sv | 114 +++++++++++
 tb/tb_bcd_serial_adder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the serial packed-BCD adder slice.
//   state_t     : controller states (IDLE, RUN, DONE)
//   BCD_DIGIT_W : bits per BCD digit
//   BCD_MAX     : largest legal BCD digit value
//   BCD_RADIX   : decimal radix, sized for the 5-bit digit sum
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [3:0]  BCD_MAX     = 4'd9;
  localparam logic [4:0]  BCD_RADIX   = 5'd10;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder, purely combinational.
//   a_d, b_d : input digits (may be illegal, i.e. > 9)
//   c_in     : decimal carry in
//   digit    : sum digit
//   c_out    : decimal carry out
//   bad      : set when either input digit is > 9
// Illegal digits are not corrected; they follow the same subtract-ten rule.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a_d,
  input  logic [3:0] b_d,
  input  logic       c_in,
  output logic [3:0] digit,
  output logic       c_out,
  output logic       bad
);

  logic [4:0] tmp;
  logic [4:0] adj;

  always_comb begin
    tmp   = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, c_in};
    adj   = tmp - BCD_RADIX;
    digit = tmp[3:0];
    c_out = 1'b0;
    if (tmp >= BCD_RADIX) begin
      digit = adj[3:0];
      c_out = 1'b1;
    end
    bad = (a_d > BCD_MAX) || (b_d > BCD_MAX);
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder, one digit per clock, LSD first, through a
// single shared bcd_digit_add stage.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake (accepted only in IDLE)
//   a, b, cin           : packed-BCD operands and carry in to digit 0
//   out_valid/out_ready : result handshake (held in DONE)
//   sum, cout, err      : packed-BCD sum, decimal carry out, illegal-digit flag
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  state_t state, state_nx;

  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] a_r, b_r;
  logic                carry;
  logic                err_r;
  logic [4*DIGITS-1:0] sum_r;

  logic [3:0] a_d, b_d, digit;
  logic       c_out, bad;
  logic       accept;

  assign accept    = (state == IDLE) && in_valid;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_r;
  assign cout      = carry;
  assign err       = err_r;

  // Select digit idx of the working operands for the shared digit adder.
  always_comb begin
    a_d = '0;
    b_d = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        a_d = a_r[i*4 +: 4];
        b_d = b_r[i*4 +: 4];
      end
    end
  end

  bcd_digit_add u_digit (
    .a_d   (a_d),
    .b_d   (b_d),
    .c_in  (carry),
    .digit (digit),
    .c_out (c_out),
    .bad   (bad)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = RUN;
      RUN:  if (idx == LAST) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      err_r <= 1'b0;
      sum_r <= '0;
    end else if (accept) begin
      a_r   <= a;
      b_r   <= b;
      carry <= cin;
      idx   <= '0;
      err_r <= 1'b0;
      sum_r <= '0;
    end else if (state == RUN) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (idx == IDX_W'(i)) sum_r[i*4 +: 4] <= digit;
      end
      carry <= c_out;
      err_r <= err_r | bad;
      // Hold idx at the last digit so it never wraps.
      if (idx != LAST) idx <= idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder.sv
module tb_bcd_serial_adder;

  localparam int unsigned D = 4;
  localparam int unsigned W = 4 * D;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
  } res_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  res_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_serial_adder #(.DIGITS(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Independent decimal model for legal operands.
  function automatic int unsigned bcd2int(input logic [W-1:0] v);
    int unsigned r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int unsigned v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < D; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r = '0;
    for (int i = 0; i < D; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Waits (bounded) until in_ready, presents operands, returns accept cycle.
  task automatic accept_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic cv, output int acc_cyc);
    int n = 0;
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    while (!in_ready && n < 30) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    in_valid = 1'b0;
    a = '1; b = '1; cin = 1'b1;  // operands are registered; scramble inputs
    chk("out_valid_after_accept", 32'(out_valid), 32'd0);
  endtask

  // Counts edges until out_valid, then checks against the scoreboard head.
  task automatic wait_result(input int hold);
    int n = 0;
    res_t e;
    while (!out_valid && n < 30) begin
      @(posedge clk); #1; n++;
    end
    chk("latency_edges", 32'(n), 32'(D));
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("sum", 32'(sum), 32'(e.sum));
      chk("cout", 32'(cout), 32'(e.cout));
      chk("err", 32'(err), 32'(e.err));
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        chk("hold_out_valid", 32'(out_valid), 32'd1);
        chk("hold_sum", 32'(sum), 32'(e.sum));
        chk("hold_cout", 32'(cout), 32'(e.cout));
        chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
    end
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input res_t exp, input int hold);
    int t;
    sb.push_back(exp);
    accept_op(av, bv, cv, t);
    wait_result(hold);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after_release", 32'(in_ready), 32'd1);
    chk("out_valid_after_release", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int t1, t2;
    logic [W-1:0] ra, rb;
    logic rc;
    int unsigned tot;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(16'h1234, 16'h5678, 1'b0, '{16'h6912, 1'b0, 1'b0}, 0);
    run_op(16'h9999, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0}, 0);
    run_op(16'h0000, 16'h0000, 1'b1, '{16'h0001, 1'b0, 1'b0}, 0);
    run_op(16'h0999, 16'h0000, 1'b1, '{16'h1000, 1'b0, 1'b0}, 0);
    run_op(16'h000B, 16'h0006, 1'b1, '{16'h0018, 1'b0, 1'b1}, 0);
    run_op(16'h0012, 16'h0034, 1'b0, '{16'h0046, 1'b0, 1'b0}, 0);
    // 15+15+1 = 31 -> digit 5, carry 1 into the next digit.
    run_op(16'h000F, 16'h000F, 1'b1, '{16'h0015, 1'b0, 1'b1}, 0);
    run_op(16'h9999, 16'h9999, 1'b1, '{16'h9999, 1'b1, 1'b0}, 0);

    // Backpressure: hold DONE for 5 cycles.
    run_op(16'h4321, 16'h1111, 1'b0, '{16'h5432, 1'b0, 1'b0}, 5);

    // Throughput with out_ready held high.
    out_ready = 1'b1;
    sb.push_back('{16'h0300, 1'b0, 1'b0});
    accept_op(16'h0100, 16'h0200, 1'b0, t1);
    wait_result(0);
    sb.push_back('{16'h0007, 1'b0, 1'b0});
    accept_op(16'h0003, 16'h0004, 1'b0, t2);
    chk("accept_to_accept", 32'(t2 - t1), 32'(D + 2));
    wait_result(0);
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Random legal operands against a decimal model.
    for (int r = 0; r < 6; r++) begin
      ra = rand_bcd();
      rb = rand_bcd();
      rc = 1'($urandom_range(0, 1));
      tot = bcd2int(ra) + bcd2int(rb) + int'(rc);
      run_op(ra, rb, rc, '{int2bcd(tot), (tot >= 10000), 1'b0}, 0);
    end

    // Reset mid-RUN after two digits.
    accept_op(16'h1234, 16'h5678, 1'b0, t1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(16'h0005, 16'h0005, 1'b0, '{16'h0010, 1'b0, 1'b0}, 0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
